// File: rtl/vx_mem_req_credit.sv
// Request-side skid buffer and outstanding-read limiter in front of the Vortex-to-AXI adapter.
// Responses pass straight through and return read credits.
module vx_mem_req_credit #(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_WIDTH    = 8,
    parameter int BYTEEN_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_PENDING  = 16,
    parameter int CNT_WIDTH    = $clog2(MAX_PENDING + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,

    input  logic                    i_core_req_valid,
    input  logic                    i_core_req_rw,
    input  logic [BYTEEN_WIDTH-1:0] i_core_req_byteen,
    input  logic [ADDR_WIDTH-1:0]   i_core_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_core_req_data,
    input  logic [TAG_WIDTH-1:0]    i_core_req_tag,
    output logic                    o_core_req_ready,

    output logic                    o_mem_req_valid,
    output logic                    o_mem_req_rw,
    output logic [BYTEEN_WIDTH-1:0] o_mem_req_byteen,
    output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_req_data,
    output logic [TAG_WIDTH-1:0]    o_mem_req_tag,
    input  logic                    i_mem_req_ready,

    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]    i_mem_rsp_tag,
    output logic                    o_mem_rsp_ready,

    output logic                    o_core_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_core_rsp_data,
    output logic [TAG_WIDTH-1:0]    o_core_rsp_tag,
    input  logic                    i_core_rsp_ready,

    output logic [CNT_WIDTH-1:0]    o_pending_count,
    output logic                    o_idle
);

    localparam int REQ_W = 1 + BYTEEN_WIDTH + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PENDING);

    logic             r_out_valid;
    logic [REQ_W-1:0] r_out_req;
    logic             r_skid_valid;
    logic [REQ_W-1:0] r_skid_req;
    logic [CNT_WIDTH-1:0] r_pending_count;

    logic             w_core_fire;
    logic             w_mem_fire;
    logic             w_out_rw;
    logic             w_credit_ok;
    logic             w_rd_fire;
    logic             w_rsp_fire;
    logic [REQ_W-1:0] w_core_req;
    logic [CNT_WIDTH-1:0] w_pending_next;

    assign w_core_req = {i_core_req_rw, i_core_req_byteen, i_core_req_addr,
                         i_core_req_data, i_core_req_tag};
    assign w_out_rw   = r_out_req[REQ_W-1];

    // Ready depends only on registered state so the adapter's ready never reaches the core.
    assign o_core_req_ready = !r_skid_valid && !i_reset;
    assign w_core_fire      = i_core_req_valid && o_core_req_ready;

    assign w_credit_ok     = w_out_rw || (r_pending_count < MAX_CNT);
    assign o_mem_req_valid = r_out_valid && w_credit_ok;
    assign w_mem_fire      = o_mem_req_valid && i_mem_req_ready;
    assign {o_mem_req_rw, o_mem_req_byteen, o_mem_req_addr,
            o_mem_req_data, o_mem_req_tag} = r_out_req;

    assign w_rd_fire  = w_mem_fire && !w_out_rw;
    assign w_rsp_fire = i_mem_rsp_valid && i_core_rsp_ready;

    assign o_core_rsp_valid = i_mem_rsp_valid;
    assign o_core_rsp_data  = i_mem_rsp_data;
    assign o_core_rsp_tag   = i_mem_rsp_tag;
    assign o_mem_rsp_ready  = i_core_rsp_ready;

    assign o_pending_count = r_pending_count;
    assign o_idle          = !r_out_valid && !r_skid_valid && (r_pending_count == '0);

    // The skid slot only fills while the output slot is held, so it is empty whenever the output slot is.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid  <= 1'b0;
            r_out_req    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_req   <= '0;
        end else if (!r_out_valid || w_mem_fire) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_req    <= r_skid_req;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_core_fire;
                if (w_core_fire) begin
                    r_out_req <= w_core_req;
                end
            end
        end else if (w_core_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_req   <= w_core_req;
        end
    end

    always_comb begin
        w_pending_next = r_pending_count;
        if (w_rd_fire && !w_rsp_fire) begin
            w_pending_next = r_pending_count + CNT_WIDTH'(1);
        end else if (!w_rd_fire && w_rsp_fire && (r_pending_count != '0)) begin
            w_pending_next = r_pending_count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending_count <= '0;
        end else begin
            r_pending_count <= w_pending_next;
        end
    end

    a_credit_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_rsp_fire && !w_rd_fire && (r_pending_count == '0)))
        else $error("credit underflow");

    a_credit_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_rd_fire && (r_pending_count == MAX_CNT)))
        else $error("credit overflow");

endmodule
